// File: rtl/axi_burst_memory.sv
// Word-addressed burst memory slave with independent AXI-style write (AW/W/B) and read (AR/R) channels.
// Incrementing bursts of up to 16 beats; the first read beat appears READ_LATENCY cycles after the AR handshake.
module axi_burst_memory #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 4096,
  parameter int READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  w_state_t         w_state;
  logic [3:0]       w_id;
  logic [IDX_W-1:0] w_idx;
  logic [4:0]       w_cnt;

  r_state_t         r_state;
  logic [3:0]       r_id;
  logic [IDX_W-1:0] r_idx;
  logic [4:0]       r_cnt;
  logic [LAT_W-1:0] r_wait;
  logic             load_beat;

  // WID, WLAST, byte offsets and address bits above the array are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{WID, WLAST, AWADDR[1:0], ARADDR[1:0],
                       AWADDR[ADDR_WIDTH-1:IDX_W+2], ARADDR[ADDR_WIDTH-1:IDX_W+2]};

  // NOTE: storage has no reset branch so it maps onto block RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (w_state == W_DATA && WVALID) mem[w_idx] <= WDATA;
  end

  // The beat count alone ends the data phase; WLAST is not consulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      w_id    <= '0;
      w_idx   <= '0;
      w_cnt   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_id    <= AWID;
            w_idx   <= AWADDR[IDX_W+1:2];
            w_cnt   <= {1'b0, AWLEN} + 5'd1;
            w_state <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            w_idx <= w_idx + IDX_W'(1);
            w_cnt <= w_cnt - 5'd1;
            if (w_cnt == 5'd1) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: a continuous assign for the beat-load strobe cannot infer a latch, unlike a partially assigned always block.
  assign load_beat = (r_state == R_WAIT && r_wait == '0) ||
                     (r_state == R_DATA && RREADY && !RLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      r_id    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            ARREADY <= 1'b0;
            r_id    <= ARID;
            r_idx   <= ARADDR[IDX_W+1:2];
            r_cnt   <= {1'b0, ARLEN} + 5'd1;
            r_wait  <= LAT_W'(READ_LATENCY - 1);
            r_state <= R_WAIT;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_wait == '0) r_state <= R_DATA;
          else              r_wait  <= r_wait - LAT_W'(1);
        end
        R_DATA: begin
          if (RREADY && RLAST) begin
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase

      // A same-edge write to this word is not visible here: the array update lands after this read.
      if (load_beat) begin
        RVALID <= 1'b1;
        RDATA  <= mem[r_idx];
        RID    <= r_id;
        RLAST  <= (r_cnt == 5'd1);
        r_idx  <= r_idx + IDX_W'(1);
        r_cnt  <= r_cnt - 5'd1;
      end
    end
  end
endmodule

// File: doc/axi_burst_memory.md
Name: axi_burst_memory

Overview:
- Simulation/FPGA main-memory slave that consumes the core's top-level AXI-style ports: AW/W/B for writes, AR/R for reads.
- Sits directly downstream of the core's memory arbiter outputs.
- Services incrementing bursts of up to 16 words with a programmable initial read latency.
- Read and write channels are independent state machines sharing one word-addressed storage array.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width; one beat = one word.
- DEPTH_WORDS, 4096, storage words (power of two).
- READ_LATENCY, 4, cycles from AR handshake to first RVALID (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWID  in  4  write transaction id
- AWLEN  in  4  beats minus one
- AWADDR  in  ADDR_WIDTH  byte start address
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WLAST  in  1  last write beat
- WID  in  4  write data id (ignored)
- WDATA  in  DATA_WIDTH  write data
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BID  out  4  response id
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARID  in  4  read id
- ARLEN  in  4  beats minus one
- ARADDR  in  ADDR_WIDTH  byte start address
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RLAST  out  1  last read beat
- RID  out  4  read id
- RDATA  out  DATA_WIDTH  read data

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset values: all outputs 0, both FSMs IDLE. Storage contents are not reset. Reset mid-burst aborts the burst; words already written are retained.
- Addressing:
  - Word index = ADDR[log2(DEPTH_WORDS)+1:2]. Byte offset bits [1:0] are ignored.
  - Index increments by 1 per beat and wraps modulo DEPTH_WORDS.
- Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch AWID, word index and beat count AWLEN+1; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID beat writes WDATA at the edge, then the index and beat counter advance.
  - Exit W_DATA after the final counted beat, regardless of WLAST. If WLAST and the count disagree, the count wins; WLAST is a bench assertion only.
  - W_RESP: BVALID=1, BID=latched id. Hold until BREADY; on BVALID&BREADY return to W_IDLE, so next AWREADY is the following cycle.
  - No AW is accepted while W_DATA or W_RESP (single outstanding write).
- Read FSM (R_IDLE -> R_WAIT -> R_DATA -> R_IDLE):
  - R_IDLE: ARREADY=1. On handshake, latch ARID, index and count ARLEN+1; load wait counter with READ_LATENCY-1; go to R_WAIT.
  - R_WAIT: counts down; at 0, registers RDATA from storage and enters R_DATA. First RVALID therefore appears exactly READ_LATENCY cycles after the AR handshake edge.
  - R_DATA: RVALID=1, RID=latched id, RLAST=1 on the final beat.
    - RDATA, RLAST and RID are held stable while RREADY=0.
    - On RVALID&RREADY with beats remaining: the next word is registered and presented the next cycle (one beat per cycle with RREADY held high).
    - On the last beat, return to R_IDLE.
  - Single outstanding read.
- Simultaneous write and read to the same word on one edge: the read beat registered on that edge returns the old value. A later beat sees the new value.
- Channels operate concurrently; there is no read/write priority.

Test Plan:
- Single write, then read: AW addr 0x40 len 0, W 0xDEADBEEF -> BVALID one cycle after the W beat, BID=AWID. AR 0x40 len 0 id 3 -> RVALID at handshake+4, RDATA 0xDEADBEEF, RLAST=1, RID=3.
- 16-beat burst: write 0x100..0x13C with data i, read back with len 15 and RREADY held 1 -> 16 consecutive beats 0..15, RLAST only on beat 15.
- Backpressure: read burst len 3, RREADY toggled 1,0,0,1,... -> RDATA/RLAST stable during stalls, no beat lost or duplicated. BREADY held 0 for 5 cycles -> BVALID held, AWREADY=0 throughout.
- Wrap: AR to last word (DEPTH_WORDS-1)*4, len 1 -> beat 1 returns word 0.
- Concurrency and collision: read burst in flight while a write updates the word of the next unissued beat -> that beat returns the new value. A same-edge collision returns the old value.
- Reset mid-burst: assert rst_n=0 during W_DATA after 2 of 4 beats -> outputs 0 asynchronously, FSMs IDLE; after release, a read shows the first 2 words updated and the last 2 unchanged.
